// File: rtl/fulladd_pkg.sv
// Shared constants and types for the clocked ripple-carry full adder.
// FULLADD_INREG_EN selects the optional input register stage (latency 2).
package fulladd_pkg;

  localparam int FULLADD_WIDTH_DEFAULT = 1;

`ifdef FULLADD_INREG_EN
  localparam int FULLADD_LATENCY = 2;
`else
  localparam int FULLADD_LATENCY = 1;
`endif

  // Carry-out concatenated with the sum, at the default width.
  typedef logic [FULLADD_WIDTH_DEFAULT:0] fa_sum_t;

endpackage

// File: rtl/fulladd_cell.sv
// Combinational 1-bit full-adder cell, the building block of the ripple chain.
module fulladd_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/fulladd.sv
// Registered WIDTH-bit ripple-carry adder built from fulladd_cell instances.
// Defining FULLADD_INREG_EN adds an input register stage (latency 1 -> 2).
module fulladd
  import fulladd_pkg::*;
#(
  parameter int WIDTH = FULLADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] f,
  output logic             cout
);

  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic             cin_reg;

`ifdef FULLADD_INREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg   <= '0;
      y_reg   <= '0;
      cin_reg <= 1'b0;
    end else begin
      x_reg   <= x;
      y_reg   <= y;
      cin_reg <= cin;
    end
  end
`else
  // Without the input stage the cell chain sees the ports directly.
  assign x_reg   = x;
  assign y_reg   = y;
  assign cin_reg = cin;
`endif

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;

  assign carry[0] = cin_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fulladd_cell u_cell (
        .x    (x_reg[gi]),
        .y    (y_reg[gi]),
        .cin  (carry[gi]),
        .s    (sum_next[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      f    <= '0;
      cout <= 1'b0;
    end else begin
      f    <= sum_next;
      cout <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_fulladd.sv
// Scoreboard bench for fulladd: drives a 1-bit and an 8-bit instance in lockstep
// and compares each registered result against a reference sum built from the queued inputs.
module tb_fulladd;

`ifdef FULLADD_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x1 = 1'b1, y1 = 1'b1, c1 = 1'b1;
  logic [7:0] x8 = 8'hFF, y8 = 8'hFF;
  logic       c8 = 1'b1;
  logic       f1, co1;
  logic [7:0] f8;
  logic       co8;

  logic [1:0] q1[$];
  logic [8:0] q8[$];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fulladd #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .cin(c1), .x(x1), .y(y1), .f(f1), .cout(co1)
  );

  fulladd #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .cin(c8), .x(x8), .y(y8), .f(f8), .cout(co8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, queue expectations, compare 1 time unit after posedge.
  task automatic step(input string tag, input logic r, input logic [2:0] v1,
                      input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [1:0] e1;
    logic [8:0] e8;
    @(negedge clk);
    rst = r;
    {x1, y1, c1} = v1;
    x8 = a;
    y8 = b;
    c8 = ci;
    if (r) begin
      // Reset discards in-flight sums; outputs stay zero until fresh data drains through.
      q1.delete();
      q8.delete();
      repeat (LAT) begin
        q1.push_back(2'b00);
        q8.push_back(9'h000);
      end
    end else begin
      q1.push_back(2'(v1[2]) + 2'(v1[1]) + 2'(v1[0]));
      q8.push_back(9'(a) + 9'(b) + 9'(ci));
    end
    @(posedge clk);
    #1;
    $display("[%0t] %s rst=%0b w1 in=%03b out=%0b%0b  w8 in=%02h+%02h+%0b out=%0b_%02h",
             $time, tag, r, v1, co1, f1, a, b, ci, co8, f8);
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check({tag, "_w1"}, 64'({co1, f1}), 64'(e1));
    end
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      check({tag, "_w8"}, 64'({co8, f8}), 64'(e8));
    end
  endtask

  initial begin
    // Reset held with all-ones inputs: outputs must remain zero.
    step("rst", 1'b1, 3'b111, 8'hFF, 8'hFF, 1'b1);
    step("rst", 1'b1, 3'b111, 8'hFF, 8'hFF, 1'b1);

    // Exhaustive 1-bit truth table, back to back.
    for (int i = 0; i < 8; i++)
      step("tt", 1'b0, 3'(i), 8'($urandom), 8'($urandom), 1'($urandom));

    // Wide boundary vectors.
    step("bnd", 1'b0, 3'b111, 8'hFF, 8'h00, 1'b1);
    step("bnd", 1'b0, 3'b000, 8'hFF, 8'hFF, 1'b1);
    step("bnd", 1'b0, 3'b101, 8'h5A, 8'h25, 1'b0);
    step("bnd", 1'b0, 3'b000, 8'h00, 8'h00, 1'b0);

    // Back-to-back random throughput.
    for (int i = 0; i < 20; i++)
      step("b2b", 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    // Reset mid-stream while results are in flight.
    step("pre", 1'b0, 3'b111, 8'hFF, 8'hFF, 1'b1);
    step("pre", 1'b0, 3'b110, 8'h80, 8'h80, 1'b1);
    step("mid", 1'b1, 3'b111, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++)
      step("post", 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    // Drain remaining in-flight results.
    repeat (LAT) step("drain", 1'b0, 3'b000, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
